// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   fwd_sel_e    : 2-bit operand forward select (none / EX / MEM / WB)
//   stage_info_t : shadow record of one in-flight instruction {rd, wen, load}
//   STAGE_BUBBLE : shadow record of a NOP / bubble (never writes, never a load)
//   stage_match  : true when a shadow stage produces the register a source reads
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_WB   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '{rd: 5'd0, wen: 1'b0, load: 1'b0};

  // wen is only ever set for rd != 0, so a match can never involve x0
  function automatic logic stage_match(input stage_info_t s,
                                       input logic [4:0]  rs,
                                       input logic        use_rs);
    return s.wen && (s.rd == rs) && use_rs;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk   : clock
//   rst   : synchronous active-low reset, clears the count
//   inc   : add one this cycle (ignored once the count is all-ones)
//   count : current count value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The count sticks at all-ones so a long run never wraps back to a small
  // value that would under-report the event.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
// Tracks the destination register of the instructions in EX, MEM and WB and
// derives forwarding selects, load-use stall, branch flush and memory freeze.
// Ports:
//   clk, rst                 : clock, synchronous active-low reset
//   id_valid                 : ID holds a real instruction
//   id_rs1/id_rs2            : source register numbers in ID
//   id_use1/id_use2          : the ID instruction actually reads rs1/rs2
//   id_rd, id_regwen         : destination and write enable of the ID instruction
//   id_load                  : the ID instruction is a load
//   ex_pcsel                 : taken branch / jump resolved in EX
//   mem_busy                 : data memory not ready
//   stall_if, stall_id       : hold PC, hold IF/ID
//   flush_id                 : turn IF/ID into a bubble
//   bubble_ex                : load a NOP into ID/EX
//   freeze                   : hold ID/EX, EX/MEM and MEM/WB
//   fwd1_sel, fwd2_sel       : operand forward selects (fwd_sel_e encoding)
//   stall_cnt, flush_cnt     : saturating load-use-stall / flush counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwen,
  input  logic             id_load,
  input  logic             ex_pcsel,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       fwd1_sel,
  output logic [1:0]       fwd2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic SLOW_LOAD = (LOAD_LATENCY == 2);

  stage_info_t ex_q, mem_q, wb_q;
  stage_info_t id_info;

  logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic load_use;
  logic stall_c, flush_c, bubble_c, freeze_c;
  fwd_sel_e fwd1_c, fwd2_c;
  logic stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Forward from the youngest stage that can supply the value. A load in EX
  // has no data yet, and with a two-cycle load a load in MEM has none either;
  // those cases are covered by the load-use stall, so they are skipped here.
  function automatic fwd_sel_e pick_fwd(input logic m_ex, input logic m_mem,
                                        input logic m_wb);
    if (m_ex && !ex_q.load) begin
      return FWD_EX;
    end else if (m_mem && !(mem_q.load && SLOW_LOAD)) begin
      return FWD_MEM;
    end else if (m_wb) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

  // Shadow record for the ID instruction; writes to x0 are treated as no write.
  always_comb begin
    id_info      = STAGE_BUBBLE;
    id_info.rd   = id_rd;
    id_info.wen  = id_regwen && (id_rd != 5'd0);
    id_info.load = id_load;
  end

  // Source/destination matches against each shadow stage, and the load-use
  // hazard: a load whose data will not be forwardable next cycle.
  always_comb begin
    ex_m1    = stage_match(ex_q,  id_rs1, id_use1);
    ex_m2    = stage_match(ex_q,  id_rs2, id_use2);
    mem_m1   = stage_match(mem_q, id_rs1, id_use1);
    mem_m2   = stage_match(mem_q, id_rs2, id_use2);
    wb_m1    = stage_match(wb_q,  id_rs1, id_use1);
    wb_m2    = stage_match(wb_q,  id_rs2, id_use2);
    load_use = id_valid &&
               ((ex_q.load && (ex_m1 || ex_m2)) ||
                (SLOW_LOAD && mem_q.load && (mem_m1 || mem_m2)));
  end

  // Control priority: memory freeze beats the branch flush (which the EX
  // stage keeps asserting until the freeze ends), and the flush beats the
  // load-use stall because the stalled instruction is being discarded anyway.
  // Everything reads as zero while reset is held.
  always_comb begin
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    freeze_c = 1'b0;
    fwd1_c   = FWD_NONE;
    fwd2_c   = FWD_NONE;
    if (rst) begin
      fwd1_c = pick_fwd(ex_m1, mem_m1, wb_m1);
      fwd2_c = pick_fwd(ex_m2, mem_m2, wb_m2);
      if (mem_busy) begin
        freeze_c = 1'b1;
        stall_c  = 1'b1;
      end else if (ex_pcsel) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (load_use) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
    end
  end

  assign stall_if  = stall_c;
  assign stall_id  = stall_c;
  assign flush_id  = flush_c;
  assign bubble_ex = bubble_c;
  assign freeze    = freeze_c;
  assign fwd1_sel  = fwd1_c;
  assign fwd2_sel  = fwd2_c;

  // Shadow pipeline mirrors the real one: it holds during a freeze and
  // otherwise shifts, with EX receiving a bubble whenever ID/EX does.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
    end else if (!freeze_c) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (bubble_c || !id_valid) ? STAGE_BUBBLE : id_info;
    end
  end

  // Count only events that actually took effect this cycle.
  assign stall_inc = rst && load_use && !mem_busy && !ex_pcsel;
  assign flush_inc = rst && ex_pcsel && !mem_busy;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt_q)
  );

  assign stall_cnt = rst ? stall_cnt_q : '0;
  assign flush_cnt = rst ? flush_cnt_q : '0;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It inspects the instruction in ID and keeps a shadow record of the destination register of each instruction in EX, MEM and WB. From these it produces forwarding selects for reg1/reg2, a load-use stall, branch/jump flush, and a whole-pipe freeze on data-memory busy. It sits beside the ID stage and drives the IF/ID, ID/EX and later pipeline-register enables, plus saturating stall and flush performance counters.

Parameters:
LOAD_LATENCY, 1, cycles after MEM before load data is forwardable (legal values 1 or 2).
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  instr[19:15]
id_rs2  in  5  instr[24:20]
id_use1  in  1  instruction reads rs1
id_use2  in  1  instruction reads rs2
id_rd  in  5  instr[11:7]
id_regwen  in  1  regwen from the control unit
id_load  in  1  instruction is a load (wbsel selects memory)
ex_pcsel  in  1  taken branch or jump resolved in EX
mem_busy  in  1  data memory not ready
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
flush_id  out  1  clear IF/ID to bubble
bubble_ex  out  1  load NOP into ID/EX
freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
fwd1_sel  out  2  forward select for reg1
fwd2_sel  out  2  forward select for reg2
stall_cnt  out  CNT_W  cycles with load-use stall
flush_cnt  out  CNT_W  flush events

Behaviour:
- Shadow stages EX, MEM, WB each hold {rd, wen, load}.
  - wen=1 only if regwen=1 and rd!=0.
  - Each cycle without freeze, shift: WB<-MEM, MEM<-EX, EX<-ID info. EX takes a bubble (wen=0) if bubble_ex=1 or id_valid=0.
  - While freeze=1, all shadow stages hold.
- Reset (rst=0 at clk edge):
  - All shadow wen=0 and both counters=0.
  - While rst=0, all outputs are forced to 0.
- Match definition: stage S matches rsN when S.wen=1, S.rd==id_rsN and id_useN=1.
- Load-use hazard (lu), for id_valid=1:
  - EX.load and EX matches rs1 or rs2; or
  - LOAD_LATENCY=2 and MEM.load and MEM matches.
- Priority, highest first:
  1. mem_busy=1: freeze=stall_if=stall_id=1; flush_id=bubble_ex=0. A concurrent ex_pcsel is deferred: it is still asserted when mem_busy drops, and the flush happens then.
  2. ex_pcsel=1: flush_id=bubble_ex=1, stall_if=stall_id=0. The PC takes the target. A simultaneous lu is discarded.
  3. lu=1: stall_if=stall_id=bubble_ex=1 for exactly one cycle per hazard (two cycles when LOAD_LATENCY=2 and the dependency is on EX).
  4. Otherwise all control outputs are 0.
- Forwarding selects (combinational, encoded FWD_NONE=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3):
  - Priority EX > MEM > WB.
  - EX is never selected when EX.load=1; that case is covered by the stall.
  - MEM is not selected for a load when LOAD_LATENCY=2.
  - rd==0 never forwards.
  - The datapath registers fwdN_sel into ID/EX together with the operands.
- Counters:
  - stall_cnt increments on each cycle with lu=1 and no higher-priority event.
  - flush_cnt increments on each cycle with ex_pcsel=1 and mem_busy=0.
  - Both saturate at all-ones and never wrap.
- Latency: all control outputs are combinational in the same cycle as their inputs. Shadow state updates at the next clk edge.

Decomposition:
- hazard_pkg holds: fwd_sel_e enum (2-bit), stage_info_t struct {rd[4:0], wen, load}, and the NOP/bubble constant.
- One sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count), instantiated twice.

Test Plan:
- Setup for each scenario: rst=0 for 2 cycles, then release. Check all outputs are 0 and counters are 0.
- ALU back-to-back: add x5 then add x6,x5,x1 -> fwd1_sel=1 on the second instruction; no stall; stall_cnt=0.
- Load-use: lw x7, then add x8,x7,x7, LOAD_LATENCY=1 -> one cycle of stall_if=stall_id=bubble_ex=1; next cycle fwd1_sel=fwd2_sel=2; stall_cnt=1.
- Branch with pending lu: ex_pcsel=1 in the same cycle as lu -> flush_id=bubble_ex=1, stall_id=0, flush_cnt=1, stall_cnt=0.
- mem_busy for 3 cycles with ex_pcsel=1 -> freeze=1 for 3 cycles, no flush. Flush occurs on the 4th cycle; shadow state unchanged across the freeze.
- Writes to x0: writer to x0 then reader of x0 -> fwd sel 0, no stall. Also check rd-match priority: EX and MEM both target x3 -> fwd=1.
- Saturation: with CNT_W=2, 5 load-use hazards -> stall_cnt=3. Then apply rst=0 mid-stall -> all outputs 0 and counters 0 next cycle.
